pong_game_ctrl: RTL and testbench

Top-level game sequencer for the Pong design. It owns the game state machine (new game, play, new ball, game over), the lives counter and the two-digit BCD score. It drives the 8-bit countdown timer instance through timer_start/timer_tick and consumes its timer_up flag to pace the serve and game-over delays. It also supplies freeze and text-overlay enables to the graphics and text blocks.

---
 rtl/pong_game_ctrl_if.sv | 32 +++
 rtl/pong_game_ctrl.sv | 121 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and its surroundings
// (buttons, collision pulses, countdown timer, graphics/text enables).
interface pong_game_ctrl_if #(
  parameter int LIVES = 3,
  parameter int BW    = $clog2(LIVES + 1)
);
  logic [1:0]    btn;
  logic          refresh_tick;
  logic          hit;
  logic          miss;
  logic          timer_up;
  logic          timer_start;
  logic          timer_tick;
  logic          graph_still;
  logic [3:0]    text_on;
  logic [7:0]    score_bcd;
  logic [BW-1:0] balls_left;
  logic [1:0]    state_o;

  // slave is the sequencer; master is whatever surrounds it
  modport slave (
    input  btn, refresh_tick, hit, miss, timer_up,
    output timer_start, timer_tick, graph_still, text_on, score_bcd,
           balls_left, state_o
  );

  modport master (
    output btn, refresh_tick, hit, miss, timer_up,
    input  timer_start, timer_tick, graph_still, text_on, score_bcd,
           balls_left, state_o
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: state machine, lives counter, BCD score and timer pacing.
// Optional macro PONG_AUTO_SERVE_EN: serve automatically when the timer expires.
module pong_game_ctrl #(
  parameter int LIVES = 3,
  parameter int BW    = $clog2(LIVES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  pong_game_ctrl_if.slave bus
);

  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] balls_q, balls_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    btn_prev_q, btn_prev_d;

  logic [7:0]    score_inc;
  logic          press;
  logic          timer_start;
  logic          timer_tick;
  logic          graph_still;
  logic [3:0]    text_on;

  // Saturating two-digit BCD increment
  always_comb begin
    if (score_q == 8'h99) begin
      score_inc = score_q;
    end else if (score_q[3:0] == 4'd9) begin
      score_inc = {score_q[7:4] + 4'd1, 4'd0};
    end else begin
      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    btn_prev_d  = bus.btn;
    press       = |(bus.btn & ~btn_prev_q);
    state_d     = state_q;
    balls_d     = balls_q;
    score_d     = score_q;
    timer_start = 1'b0;
    graph_still = 1'b1;
    text_on     = 4'b0111;

    case (state_q)
      ST_NEWGAME: begin
        if (press) begin
          state_d = ST_PLAY;
          score_d = 8'h00;
          balls_d = BW'(LIVES);
        end
      end
      ST_PLAY: begin
        graph_still = 1'b0;
        text_on     = 4'b0001;
        // A miss takes priority over a coincident hit and arms the serve delay
        if (bus.miss) begin
          timer_start = 1'b1;
          balls_d     = balls_q - BW'(1);
          state_d     = (balls_q == BW'(1)) ? ST_OVER : ST_NEWBALL;
        end else if (bus.hit) begin
          score_d = score_inc;
        end
      end
      ST_NEWBALL: begin
        text_on = 4'b0001;
`ifdef PONG_AUTO_SERVE_EN
        if (bus.timer_up) begin
          state_d = ST_PLAY;
        end
`else
        if (bus.timer_up && press) begin
          state_d = ST_PLAY;
        end
`endif
      end
      ST_OVER: begin
        text_on = 4'b1001;
        if (bus.timer_up) begin
          state_d = ST_NEWGAME;
          balls_d = BW'(LIVES);
        end
      end
      default: begin
        state_d = ST_NEWGAME;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_NEWGAME;
      balls_q    <= BW'(LIVES);
      score_q    <= 8'h00;
      btn_prev_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      balls_q    <= balls_d;
      score_q    <= score_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  // Timer strobes are suppressed while reset is held
  assign timer_tick = bus.refresh_tick &&
                      ((state_q == ST_NEWBALL) || (state_q == ST_OVER));

  assign bus.timer_start = reset_n & timer_start;
  assign bus.timer_tick  = reset_n & timer_tick;
  assign bus.graph_still = graph_still;
  assign bus.text_on     = text_on;
  assign bus.score_bcd   = score_q;
  assign bus.balls_left  = balls_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl with a behavioural 8-bit countdown timer.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  localparam int LIVES = 3;
  localparam int BW    = $clog2(LIVES + 1);

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic     clk = 1'b0;
  logic     reset_n = 1'b0;
  logic [7:0] tmr = 8'd0;
  int       tick_cnt = 0;
  int       n_cmp = 0;
  int       n_fail = 0;
  int       score_m = 0;
  int       tick_base;
  sb_item_t sb[$];

  pong_game_ctrl_if #(.LIVES(LIVES), .BW(BW)) bus ();

  pong_game_ctrl #(.LIVES(LIVES), .BW(BW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Countdown timer: reload 255, decrement on tick, flag at zero
  always @(posedge clk) begin
    if (bus.timer_start) tmr <= 8'd255;
    else if (bus.timer_tick && tmr != 8'd0) tmr <= tmr - 8'd1;
    if (bus.timer_tick) tick_cnt <= tick_cnt + 1;
  end
  assign bus.timer_up = (tmr == 8'd0);

  function automatic logic [31:0] bcd(input int s);
    return 32'((s / 10) * 16 + (s % 10));
  endfunction

  task automatic pushExpect(input string tag, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs);
    sb_item_t it;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, no expectation queued", tag, obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp && tag == it.tag) else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0h expected %0h (queued tag %s)",
               tag, obs, it.exp, it.tag);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] b, input logic h, input logic m,
                               input logic r);
    bus.btn          = b;
    bus.hit          = h;
    bus.miss         = m;
    bus.refresh_tick = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // 255 frames of countdown, then a press (unless serving automatically)
  task automatic serve();
    for (int i = 0; i < 255; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
      step();
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("timer_up_after_countdown", 32'd1);
    checkOutput("timer_up_after_countdown", 32'(bus.timer_up));
`ifndef PONG_AUTO_SERVE_EN
    pushExpect("waiting_for_press", 32'd2);
    checkOutput("waiting_for_press", 32'(bus.state_o));
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
`endif
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("served_play", 32'd1);
    checkOutput("served_play", 32'(bus.state_o));
  endtask

  task automatic hitOnce();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    if (score_m < 99) score_m++;
  endtask

  task automatic missOnce();
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    pushExpect("timer_start_on_miss", 32'd1);
    checkOutput("timer_start_on_miss", 32'(bus.timer_start));
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset with btn[0] held, release, then press btn[1]
    reset_n = 1'b0;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
    pushExpect("tick_in_reset", 32'd0);
    checkOutput("tick_in_reset", 32'(bus.timer_tick));
    step();
    step();
    pushExpect("rst_state", 32'd0);
    pushExpect("rst_balls", 32'd3);
    pushExpect("rst_score", 32'h00);
    checkOutput("rst_state", 32'(bus.state_o));
    checkOutput("rst_balls", 32'(bus.balls_left));
    checkOutput("rst_score", 32'(bus.score_bcd));
    reset_n = 1'b1;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    pushExpect("held_btn_state", 32'd0);
    pushExpect("newgame_text", 32'b0111);
    pushExpect("newgame_still", 32'd1);
    checkOutput("held_btn_state", 32'(bus.state_o));
    checkOutput("newgame_text", 32'(bus.text_on));
    checkOutput("newgame_still", 32'(bus.graph_still));
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("start_state", 32'd1);
    pushExpect("start_score", 32'h00);
    pushExpect("start_balls", 32'd3);
    pushExpect("play_still", 32'd0);
    pushExpect("play_text", 32'b0001);
    checkOutput("start_state", 32'(bus.state_o));
    checkOutput("start_score", 32'(bus.score_bcd));
    checkOutput("start_balls", 32'(bus.balls_left));
    checkOutput("play_still", 32'(bus.graph_still));
    checkOutput("play_text", 32'(bus.text_on));

    // 2: 12 hits, then coincident hit+miss
    score_m = 0;
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    pushExpect("no_start_on_hit", 32'd0);
    checkOutput("no_start_on_hit", 32'(bus.timer_start));
    for (int i = 0; i < 12; i++) hitOnce();
    pushExpect("score_12", bcd(score_m));
    checkOutput("score_12", 32'(bus.score_bcd));
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
    pushExpect("timer_start_hitmiss", 32'd1);
    checkOutput("timer_start_hitmiss", 32'(bus.timer_start));
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("timer_start_drop", 32'd0);
    pushExpect("newball_state", 32'd2);
    pushExpect("newball_balls", 32'd2);
    pushExpect("hitmiss_score", 32'h12);
    pushExpect("timer_up_first_cycle", 32'd0);
    pushExpect("newball_still", 32'd1);
    checkOutput("timer_start_drop", 32'(bus.timer_start));
    checkOutput("newball_state", 32'(bus.state_o));
    checkOutput("newball_balls", 32'(bus.balls_left));
    checkOutput("hitmiss_score", 32'(bus.score_bcd));
    checkOutput("timer_up_first_cycle", 32'(bus.timer_up));
    checkOutput("newball_still", 32'(bus.graph_still));

    // hit outside PLAY is ignored
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("hit_in_newball", 32'h12);
    checkOutput("hit_in_newball", 32'(bus.score_bcd));

    // 4: early press discarded, 255 ticks, then serve
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    pushExpect("early_press_ignored", 32'd2);
    checkOutput("early_press_ignored", 32'(bus.state_o));
    tick_base = tick_cnt;
    serve();
    pushExpect("tick_count_serve", 32'd255);
    checkOutput("tick_count_serve", 32'(tick_cnt - tick_base));

    // 3: climb to 98, then saturate at 99
    while (score_m < 98) hitOnce();
    pushExpect("score_98", 32'h98);
    checkOutput("score_98", 32'(bus.score_bcd));
    for (int i = 0; i < 3; i++) begin
      hitOnce();
      pushExpect("score_sat", 32'h99);
      checkOutput("score_sat", 32'(bus.score_bcd));
    end

    // 5: remaining two misses end the game
    missOnce();
    pushExpect("second_miss_balls", 32'd1);
    checkOutput("second_miss_balls", 32'(bus.balls_left));
    serve();
    missOnce();
    pushExpect("over_state", 32'd3);
    pushExpect("over_balls", 32'd0);
    pushExpect("over_text", 32'b1001);
    checkOutput("over_state", 32'(bus.state_o));
    checkOutput("over_balls", 32'(bus.balls_left));
    checkOutput("over_text", 32'(bus.text_on));
    tick_base = tick_cnt;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
      step();
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    pushExpect("over_hold", 32'd3);
    pushExpect("tick_count_over", 32'd255);
    checkOutput("over_hold", 32'(bus.state_o));
    checkOutput("tick_count_over", 32'(tick_cnt - tick_base));
    step();
    pushExpect("over_to_newgame", 32'd0);
    pushExpect("over_reload_balls", 32'd3);
    checkOutput("over_to_newgame", 32'(bus.state_o));
    checkOutput("over_reload_balls", 32'(bus.balls_left));

    // 6: second game, reset during OVER with refresh active
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    score_m = 0;
    pushExpect("game2_score_clear", 32'h00);
    checkOutput("game2_score_clear", 32'(bus.score_bcd));
    for (int i = 0; i < 5; i++) hitOnce();
    pushExpect("game2_score", bcd(score_m));
    checkOutput("game2_score", 32'(bus.score_bcd));
    missOnce();
    serve();
    missOnce();
    serve();
    missOnce();
    pushExpect("game2_over", 32'd3);
    checkOutput("game2_over", 32'(bus.state_o));
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    step();
    reset_n = 1'b0;
    #1;
    pushExpect("tick_gated_by_reset", 32'd0);
    pushExpect("start_gated_by_reset", 32'd0);
    checkOutput("tick_gated_by_reset", 32'(bus.timer_tick));
    checkOutput("start_gated_by_reset", 32'(bus.timer_start));
    step();
    reset_n = 1'b1;
    #1;
    pushExpect("midrst_state", 32'd0);
    pushExpect("midrst_score", 32'h00);
    pushExpect("midrst_balls", 32'd3);
    pushExpect("midrst_tick", 32'd0);
    pushExpect("midrst_start", 32'd0);
    checkOutput("midrst_state", 32'(bus.state_o));
    checkOutput("midrst_score", 32'(bus.score_bcd));
    checkOutput("midrst_balls", 32'(bus.balls_left));
    checkOutput("midrst_tick", 32'(bus.timer_tick));
    checkOutput("midrst_start", 32'(bus.timer_start));

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
